// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice: the arbiter FSM
// state encoding and the default requester count / start timeout used as
// parameter defaults by the interface, the picker and the arbiter top.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Default number of byte requesters sharing the UART.
    localparam int DEFAULT_N_REQ         = 4;

    // Default number of cycles to wait for the UART to report busy after a
    // transmit strobe before the byte is given up.
    localparam int DEFAULT_START_TIMEOUT = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,  // looking for an eligible requester
        ISSUE      = 2'd1,  // one-cycle transmit strobe to the UART
        WAIT_START = 2'd2,  // waiting for the UART to go busy
        WAIT_DONE  = 2'd3   // waiting for the UART to finish the byte
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Byte-requester bus between N_REQ producers and the UART transmit arbiter.
//   req_valid [N_REQ]    requester i offers a byte
//   req_data  [8*N_REQ]  byte of requester i at bits [8i+7:8i]
//   req_last  [N_REQ]    the offered byte ends requester i's packet
//   req_ready [N_REQ]    one-hot: requester i's byte is taken on this edge
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ
) ();

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );

endinterface

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Rotating-priority search: returns the first set bit of req, scanning
// upward from ptr and wrapping past N_REQ-1 back to 0.
//   req       [N_REQ]        request vector
//   ptr       [clog2(N_REQ)] index that currently has highest priority
//   grant     [N_REQ]        one-hot winner (all zero when req is zero)
//   grant_idx [clog2(N_REQ)] index of the winner (0 when req is zero)
//   any                      at least one request present
// Purely combinational.
// ---------------------------------------------------------------------------
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand     = (int'(ptr) + off) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte requesters. Bytes are taken
// one at a time with rotating priority; with LOCK_PACKETS=1 a requester
// keeps the UART until it sends the byte flagged last. Each byte is strobed
// into the UART, and the arbiter waits for the UART to start and finish
// before taking the next byte. A UART that does not start within
// START_TIMEOUT cycles raises start_error and the byte is dropped.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_bus (slave)        requester valid/data/last/ready bus
//   uart_transmit          one-cycle strobe to the UART
//   uart_tx_byte  [8]      byte for the UART, stable until back in IDLE
//   uart_is_transmitting   UART busy flag
//   grant_id [clog2 N_REQ] current or most recent owner
//   busy                   FSM active or a packet lock is held
//   start_error            one-cycle pulse on UART start timeout
//   bytes_sent    [16]     bytes completed by the UART, wrapping
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = DEFAULT_N_REQ,
    parameter int LOCK_PACKETS  = 1,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_arbiter_if.slave         req_bus,
    output logic                     uart_transmit,
    output logic [7:0]               uart_tx_byte,
    input  logic                     uart_is_transmitting,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     start_error,
    output logic [15:0]              bytes_sent
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic             lock_held;
    logic [IDX_W-1:0] lock_owner;
    logic [TMR_W-1:0] start_timer;
    logic             timeout;
    logic             accept;
    logic             pick_last;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    // While a packet is locked only its owner may compete; everyone else
    // simply waits until the owner's last byte goes through.
    always_comb begin
        eligible = req_bus.req_valid;
        if (lock_held) begin
            eligible = req_bus.req_valid & (N_REQ'(1) << lock_owner);
        end
    end

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign pick_last = req_bus.req_last[pick_idx];
    // The WAIT_START cycle that reaches this count is the last one allowed.
    assign timeout   = (start_timer == TMR_W'(START_TIMEOUT - 1));
    assign busy      = (state != IDLE) || lock_held;

    // Next-state and strobe decode. The strobes are masked while rst is high
    // so a reset never lets a byte be accepted, strobed or reported as a
    // start failure on its way out.
    always_comb begin
        state_next        = state;
        accept            = 1'b0;
        uart_transmit     = 1'b0;
        start_error       = 1'b0;
        req_bus.req_ready = '0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    accept            = 1'b1;
                    req_bus.req_ready = pick_grant;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                uart_transmit = 1'b1;
                state_next    = WAIT_START;
            end
            WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_next = WAIT_DONE;
                end else if (timeout) begin
                    start_error = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            accept            = 1'b0;
            uart_transmit     = 1'b0;
            start_error       = 1'b0;
            req_bus.req_ready = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            lock_held    <= 1'b0;
            lock_owner   <= '0;
            start_timer  <= '0;
            grant_id     <= '0;
            bytes_sent   <= '0;
            // NOTE: the byte holding register is reset only because its value
            // is visible on uart_tx_byte; pure storage with no observable
            // reset value would be left without one.
            uart_tx_byte <= '0;
        end else begin
            state       <= state_next;
            start_timer <= (state == WAIT_START) ? start_timer + TMR_W'(1) : '0;

            if (accept) begin
                uart_tx_byte <= req_bus.req_data[8*pick_idx +: 8];
                grant_id     <= pick_idx;
                if (LOCK_PACKETS != 0) begin
                    lock_held  <= !pick_last;
                    lock_owner <= pick_idx;
                end
                // Priority only rotates once the winner no longer holds the
                // UART, so a locked packet does not move the pointer.
                if (LOCK_PACKETS == 0 || pick_last) begin
                    rr_ptr <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
                end
            end

            // A dropped byte breaks the packet, so the owner loses the lock.
            if (start_error) begin
                lock_held <= 1'b0;
            end

            if (state == WAIT_DONE && !uart_is_transmitting) begin
                bytes_sent <= bytes_sent + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N_REQ=4, LOCK_PACKETS=1,
// START_TIMEOUT=4). Each test pushes the expected (requester, byte) strobe
// sequence into a scoreboard when it loads the requester sources; a monitor
// pops and compares on every uart_transmit strobe. A simple UART model
// raises uart_is_transmitting one cycle after a strobe for busy_len cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic [1:0] grant_id;
    logic       busy;
    logic       start_error;
    logic [15:0] bytes_sent;

    uart_tx_arbiter_if #(.N_REQ(N)) req_bus ();

    uart_tx_arbiter #(
        .N_REQ         (N),
        .LOCK_PACKETS  (1),
        .START_TIMEOUT (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_bus              (req_bus.slave),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .grant_id             (grant_id),
        .busy                 (busy),
        .start_error          (start_error),
        .bytes_sent           (bytes_sent)
    );

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    // Requester sources: {last, data} per entry, consumed head to tail.
    logic [8:0] src_mem [N][16];
    int         src_head [N];
    int         src_tail [N];
    logic [N-1:0] acc_mask;

    bit  uart_en;
    int  busy_len;
    int  start_err_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #2;
    endtask

    task automatic src_push(input int id, input logic last, input logic [7:0] data);
        src_mem[id][src_tail[id]] = {last, data};
        src_tail[id]++;
    endtask

    task automatic sb_push(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic flush_sources();
        for (int i = 0; i < N; i++) src_head[i] = src_tail[i];
    endtask

    task automatic wait_strobe(input string tag);
        bit seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            sync();
            if (uart_transmit) seen = 1;
        end
        check(tag, 32'(seen), 1);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        bit seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            sync();
            if (int'(bytes_sent) >= n) seen = 1;
        end
        check(tag, 32'(seen), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_sources();
        sync();
        sync();
        check("rst_busy",        32'(busy), 0);
        check("rst_grant_id",    32'(grant_id), 0);
        check("rst_bytes_sent",  32'(bytes_sent), 0);
        check("rst_transmit",    32'(uart_transmit), 0);
        check("rst_tx_byte",     32'(uart_tx_byte), 0);
        check("rst_start_error", 32'(start_error), 0);
        check("rst_ready",       32'(req_bus.req_ready), 0);
        rst = 1'b0;
    endtask

    // Requester driver: presents each source's head entry and retires it
    // after the edge on which its ready was high.
    initial begin
        req_bus.req_valid = '0;
        req_bus.req_data  = '0;
        req_bus.req_last  = '0;
        acc_mask          = '0;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) src_head[i]++;
            end
            for (int i = 0; i < N; i++) begin
                if (src_head[i] != src_tail[i]) begin
                    req_bus.req_valid[i]        = 1'b1;
                    req_bus.req_last[i]         = src_mem[i][src_head[i]][8];
                    req_bus.req_data[8*i +: 8]  = src_mem[i][src_head[i]][7:0];
                end else begin
                    req_bus.req_valid[i]        = 1'b0;
                    req_bus.req_last[i]         = 1'b0;
                    req_bus.req_data[8*i +: 8]  = 8'h00;
                end
            end
            #1;
            acc_mask = req_bus.req_ready;
        end
    end

    // UART model.
    initial begin
        uart_is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_en && uart_transmit) begin
                @(negedge clk);
                uart_is_transmitting = 1'b1;
                repeat (busy_len) @(negedge clk);
                uart_is_transmitting = 1'b0;
            end
        end
    end

    // Strobe monitor / scoreboard consumer.
    initial begin
        forever begin
            @(negedge clk);
            if (start_error) start_err_cnt++;
            if (uart_transmit) begin
                check("sb_has_entry", 32'(sb.size() != 0), 1);
                check("strobe_uart_idle", 32'(uart_is_transmitting), 0);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_grant_id", 32'(grant_id), 32'(e.id));
                    check("strobe_tx_byte", 32'(uart_tx_byte), 32'(e.data));
                end
            end
        end
    end

    initial begin
        int  base;
        int  k;
        bit  got;

        rst      = 1'b1;
        uart_en  = 1'b1;
        busy_len = 3;

        // Reset state.
        do_reset();

        // Test 1: single byte from requester 2.
        sb_push(2, 8'hA5);
        src_push(2, 1'b1, 8'hA5);
        sync();
        check("t1_ready_onehot", 32'(req_bus.req_ready), 32'b0100);
        sync();
        check("t1_ready_cleared", 32'(req_bus.req_ready), 0);
        check("t1_transmit", 32'(uart_transmit), 1);
        check("t1_tx_byte", 32'(uart_tx_byte), 32'hA5);
        check("t1_busy", 32'(busy), 1);
        sync();
        check("t1_transmit_one_cycle", 32'(uart_transmit), 0);
        wait_bytes("t1_done_in_time", 1);
        check("t1_bytes_sent", 32'(bytes_sent), 1);
        check("t1_tx_byte_held", 32'(uart_tx_byte), 32'hA5);
        check("t1_idle", 32'(busy), 0);

        // Test 2: four single-byte packets, rotation 0,1,2,3,0.
        do_reset();
        src_push(0, 1'b1, 8'h10);
        src_push(0, 1'b1, 8'h14);
        src_push(1, 1'b1, 8'h11);
        src_push(2, 1'b1, 8'h12);
        src_push(3, 1'b1, 8'h13);
        sb_push(0, 8'h10);
        sb_push(1, 8'h11);
        sb_push(2, 8'h12);
        sb_push(3, 8'h13);
        sb_push(0, 8'h14);
        wait_bytes("t2_done_in_time", 5);
        check("t2_bytes_sent", 32'(bytes_sent), 5);
        check("t2_sb_drained", 32'(sb.size()), 0);

        // Test 3: locked 3-byte packet from requester 1 while 0 waits.
        // The pointer sits at 1 after requester 0 won last.
        src_push(1, 1'b0, 8'h21);
        src_push(1, 1'b0, 8'h22);
        src_push(1, 1'b1, 8'h23);
        src_push(0, 1'b1, 8'h30);
        sb_push(1, 8'h21);
        sb_push(1, 8'h22);
        sb_push(1, 8'h23);
        sb_push(0, 8'h30);
        wait_bytes("t3_done_in_time", 9);
        check("t3_bytes_sent", 32'(bytes_sent), 9);
        check("t3_sb_drained", 32'(sb.size()), 0);
        check("t3_no_start_error", 32'(start_err_cnt), 0);
        check("t3_idle", 32'(busy), 0);

        // Test 4: UART never starts; byte opens a packet so the lock must
        // be released by the timeout.
        uart_en = 1'b0;
        base    = int'(bytes_sent);
        src_push(2, 1'b0, 8'h44);
        sb_push(2, 8'h44);
        wait_strobe("t4_strobe_seen");
        k   = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            sync();
            k++;
            if (start_error) got = 1;
        end
        check("t4_err_seen", 32'(got), 1);
        check("t4_err_delay", 32'(k), 4);
        sync();
        check("t4_err_one_cycle", 32'(start_error), 0);
        check("t4_idle_unlocked", 32'(busy), 0);
        check("t4_bytes_unchanged", 32'(bytes_sent), 32'(base));
        check("t4_err_count", 32'(start_err_cnt), 1);
        check("t4_sb_drained", 32'(sb.size()), 0);

        // Test 5: reset during WAIT_DONE with requester 3 holding a lock.
        uart_en  = 1'b1;
        busy_len = 8;
        src_push(3, 1'b0, 8'h51);
        src_push(3, 1'b1, 8'h52);
        sb_push(3, 8'h51);
        wait_strobe("t5_strobe_seen");
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            sync();
            if (uart_is_transmitting) got = 1;
        end
        check("t5_uart_started", 32'(got), 1);
        sync();
        check("t5_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        flush_sources();
        sync();
        check("t5_rst_busy",        32'(busy), 0);
        check("t5_rst_grant_id",    32'(grant_id), 0);
        check("t5_rst_bytes_sent",  32'(bytes_sent), 0);
        check("t5_rst_transmit",    32'(uart_transmit), 0);
        check("t5_rst_tx_byte",     32'(uart_tx_byte), 0);
        check("t5_rst_start_error", 32'(start_error), 0);
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            sync();
            if (!uart_is_transmitting) got = 1;
        end
        check("t5_uart_drained", 32'(got), 1);
        sync();
        rst = 1'b0;
        src_push(0, 1'b1, 8'h70);
        src_push(3, 1'b1, 8'h71);
        sb_push(0, 8'h70);
        sb_push(3, 8'h71);
        wait_bytes("t5_done_in_time", 2);
        check("t5_bytes_sent", 32'(bytes_sent), 2);
        check("t5_sb_drained", 32'(sb.size()), 0);
        check("t5_no_new_start_error", 32'(start_err_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, sets the number of byte requesters; legal range 2..8.
REQ-002 Parameter LOCK_PACKETS, default 1; 1 keeps the grant with one requester until it sends the byte tagged last, 0 re-arbitrates every byte.
REQ-003 Parameter START_TIMEOUT, default 4; the maximum number of cycles to wait for uart_is_transmitting after a transmit pulse.
REQ-004 clk  input  1  master clock, the same clock that drives the UART.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_REQ  requester i offers a byte.
REQ-007 req_data  input  8*N_REQ  byte of requester i at bits [8i+7:8i].
REQ-008 req_last  input  N_REQ  the offered byte ends requester i's packet.
REQ-009 req_ready  output  N_REQ  one-hot, combinational; the byte of requester i is accepted on this clock edge.
REQ-010 uart_transmit  output  1  one-cycle transmit strobe to the UART.
REQ-011 uart_tx_byte  output  8  byte presented to the UART; held stable from the strobe until the arbiter returns to IDLE.
REQ-012 uart_is_transmitting  input  1  UART transmit-busy flag.
REQ-013 grant_id  output  clog2(N_REQ)  index of the current or most recent owner.
REQ-014 busy  output  1  high when state is not IDLE or a packet lock is held.
REQ-015 start_error  output  1  one-cycle pulse when the UART fails to start in time.
REQ-016 bytes_sent  output  16  count of bytes the UART has completed; wraps from 0xFFFF to 0.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-018 IDLE: when any eligible req_valid is high, the arbiter SHALL raise req_ready for the winner only, latch that requester's data and last flag and index, and move to ISSUE on the same edge.
REQ-019 Eligible requesters: all of them when no lock is held; only the locked owner while a lock is held; others wait indefinitely.
REQ-020 The winner SHALL be the first requester with req_valid high, searching upward with wrap from pointer rr_ptr.
REQ-021 rr_ptr SHALL become (winner+1) mod N_REQ when a byte is accepted and no lock remains after it; otherwise rr_ptr is unchanged.
REQ-022 When LOCK_PACKETS=1, accepting a byte with req_last=0 SHALL set the lock to the winner, and accepting a byte with req_last=1 SHALL clear the lock.
REQ-023 ISSUE: uart_transmit SHALL be high for exactly this one cycle, with uart_tx_byte equal to the latched byte, and the FSM moves to WAIT_START.
REQ-024 WAIT_START: uart_is_transmitting=1 SHALL move the FSM to WAIT_DONE; START_TIMEOUT cycles without it SHALL pulse start_error, clear the lock and return the FSM to IDLE (the byte is dropped).
REQ-025 WAIT_DONE: uart_is_transmitting=0 SHALL increment bytes_sent and return the FSM to IDLE.
REQ-026 Latency: the first uart_transmit SHALL come 1 cycle after acceptance; the next acceptance comes no earlier than 1 cycle after uart_is_transmitting falls.
REQ-027 req_ready SHALL be all-zero outside IDLE and whenever no eligible valid is present.
REQ-028 A requester with req_valid=1 and N_REQ=any SHALL be served within N_REQ-1 foreign packets (fairness bound).

Reset
REQ-029 rst SHALL force state=IDLE, rr_ptr=0, lock cleared, grant_id=0, bytes_sent=0, uart_transmit=0, uart_tx_byte=0, start_error=0 and busy=0 on the next edge.
REQ-030 rst asserted mid-operation SHALL abandon the byte in flight without a start_error pulse.

Structure
REQ-031 The FSM state encoding and the default N_REQ and START_TIMEOUT constants SHALL reside in the shared package uart_pkg.
REQ-032 The rotating priority search SHALL be the sub-module uart_rr_pick (inputs: request vector and pointer; outputs: one-hot grant and index).

Verification
REQ-033 Test 1: only req 2 is valid with 0xA5 and last=1 -> req_ready=0b0100 for 1 cycle, uart_transmit 1 cycle later with uart_tx_byte=0xA5, and bytes_sent=1 after the UART goes idle.
REQ-034 Test 2: all 4 requesters hold a single-byte packet each after reset -> the grant order is 0,1,2,3,0, and each byte is serialized completely before the next strobe.
REQ-035 Test 3: LOCK_PACKETS=1, req 1 sends 3 bytes (last on the third) while req 0 is valid throughout -> req 1's 3 bytes go contiguously, and req 0 is served next.
REQ-036 Test 4: UART tied not-busy -> start_error pulses 4 cycles after the strobe, the FSM returns to IDLE, and bytes_sent is unchanged.
REQ-037 Test 5: rst is asserted during WAIT_DONE with the lock held -> all outputs take their reset values, and the next grant goes to req 0.
